// File: rtl/aes_round_sequencer.sv
// Moore sequencer for the multi-cycle AES-128 inverse-cipher datapath: load, key expansion, rounds, done.
// Optional busy-cycle counter on CYCLE_CNT when AES_SEQ_CYCLE_CNT_EN is defined.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS    = 10,
    parameter int KEYEXP_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        AES_START,
    output logic        AES_DONE,
    output logic        BUSY,
    output logic        KEYEXP_EN,
    output logic        STATE_LD,
    output logic [2:0]  OP_SEL,
    output logic [3:0]  ROUND_IDX,
    output logic [1:0]  COL_IDX
`ifdef AES_SEQ_CYCLE_CNT_EN
   ,output logic [15:0] CYCLE_CNT
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_KEYEXP, S_ARK0, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ARK  = 3'd2;
    localparam logic [2:0] OP_ISR  = 3'd3;
    localparam logic [2:0] OP_ISB  = 3'd4;
    localparam logic [2:0] OP_IMC  = 3'd5;

    localparam logic [3:0] LP_ROUND_FIRST = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] LP_ROUND_KEY   = 4'(NUM_ROUNDS);
    localparam logic [7:0] LP_KEXP_LAST   = 8'(KEYEXP_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_round, w_round_nxt;
    logic [7:0] r_kexp,  w_kexp_nxt;
    logic [1:0] r_col,   w_col_nxt;
    logic       w_busy;

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_kexp  <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_kexp  <= w_kexp_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_kexp_nxt  = r_kexp;
        w_col_nxt   = r_col;
        unique case (r_state)
            S_IDLE:   if (AES_START) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_state_nxt = S_KEYEXP;
                w_kexp_nxt  = '0;
            end
            S_KEYEXP: begin
                if (r_kexp < LP_KEXP_LAST) w_kexp_nxt  = r_kexp + 8'd1;
                else                       w_state_nxt = S_ARK0;
            end
            S_ARK0: begin
                w_state_nxt = S_ISR;
                w_round_nxt = LP_ROUND_FIRST;
            end
            S_ISR:    w_state_nxt = S_ISB;
            S_ISB:    w_state_nxt = S_ARK;
            S_ARK: begin
                if (r_round != 4'd0) begin
                    w_state_nxt = S_IMC;
                    w_col_nxt   = 2'd0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_IMC: begin
                w_col_nxt = r_col + 2'd1;
                // IMC is only entered with r != 0, so this decrement cannot wrap.
                if (r_col == 2'd3) begin
                    w_state_nxt = S_ISR;
                    w_round_nxt = r_round - 4'd1;
                end
            end
            S_DONE:   if (!AES_START) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        // Dropping start aborts any busy state, including the final ARK -> DONE edge.
        if (w_busy && !AES_START) w_state_nxt = S_IDLE;
        if (w_state_nxt == S_IDLE) begin
            w_round_nxt = '0;
            w_kexp_nxt  = '0;
            w_col_nxt   = '0;
        end
    end

    always_comb begin
        AES_DONE  = 1'b0;
        BUSY      = w_busy;
        KEYEXP_EN = 1'b0;
        STATE_LD  = 1'b0;
        OP_SEL    = OP_NOP;
        ROUND_IDX = '0;
        COL_IDX   = '0;
        unique case (r_state)
            S_IDLE:   ;
            S_LOAD: begin
                OP_SEL   = OP_LOAD;
                STATE_LD = 1'b1;
            end
            S_KEYEXP: KEYEXP_EN = 1'b1;
            S_ARK0: begin
                OP_SEL    = OP_ARK;
                ROUND_IDX = LP_ROUND_KEY;
                STATE_LD  = 1'b1;
            end
            S_ISR: begin
                OP_SEL   = OP_ISR;
                STATE_LD = 1'b1;
            end
            S_ISB: begin
                OP_SEL   = OP_ISB;
                STATE_LD = 1'b1;
            end
            S_ARK: begin
                OP_SEL    = OP_ARK;
                ROUND_IDX = r_round;
                STATE_LD  = 1'b1;
            end
            S_IMC: begin
                OP_SEL   = OP_IMC;
                COL_IDX  = r_col;
                STATE_LD = 1'b1;
            end
            S_DONE:   AES_DONE = 1'b1;
            default:  ;
        endcase
    end

`ifdef AES_SEQ_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE && w_state_nxt == S_LOAD) begin
            r_cycle_cnt <= '0;
        end else if (w_busy && r_cycle_cnt != 16'hFFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign CYCLE_CNT = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: default instance (10 rounds, 2 key-expansion cycles)
// and a small instance (2 rounds, 1 cycle), checked cycle by cycle against a sequence model.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start_d = 1'b0;
    logic start_s = 1'b0;

    logic       done_d, busy_d, kexp_d, ld_d;
    logic [2:0] op_d;
    logic [3:0] ridx_d;
    logic [1:0] col_d;
    logic       done_s, busy_s, kexp_s, ld_s;
    logic [2:0] op_s;
    logic [3:0] ridx_s;
    logic [1:0] col_s;
`ifdef AES_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_d, cnt_s;
`endif

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(10), .KEYEXP_CYCLES(2)) dut (
        .CLK(clk), .RESET_N(rst_n), .AES_START(start_d),
        .AES_DONE(done_d), .BUSY(busy_d), .KEYEXP_EN(kexp_d), .STATE_LD(ld_d),
        .OP_SEL(op_d), .ROUND_IDX(ridx_d), .COL_IDX(col_d)
`ifdef AES_SEQ_CYCLE_CNT_EN
       ,.CYCLE_CNT(cnt_d)
`endif
    );

    aes_round_sequencer #(.NUM_ROUNDS(2), .KEYEXP_CYCLES(1)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .AES_START(start_s),
        .AES_DONE(done_s), .BUSY(busy_s), .KEYEXP_EN(kexp_s), .STATE_LD(ld_s),
        .OP_SEL(op_s), .ROUND_IDX(ridx_s), .COL_IDX(col_s)
`ifdef AES_SEQ_CYCLE_CNT_EN
       ,.CYCLE_CNT(cnt_s)
`endif
    );

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       kexp;
        logic       ld;
        logic [2:0] op;
        logic [3:0] ridx;
        logic [1:0] col;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    function automatic obs_t mk(input int d, input int b, input int kx, input int l,
                                input int op, input int ri, input int cl);
        obs_t o;
        o.done = d[0];
        o.busy = b[0];
        o.kexp = kx[0];
        o.ld   = l[0];
        o.op   = op[2:0];
        o.ridx = ri[3:0];
        o.col  = cl[1:0];
        return o;
    endfunction

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.done = done_d; o.busy = busy_d; o.kexp = kexp_d; o.ld = ld_d;
            o.op = op_d; o.ridx = ridx_d; o.col = col_d;
        end else begin
            o.done = done_s; o.busy = busy_s; o.kexp = kexp_s; o.ld = ld_s;
            o.op = op_s; o.ridx = ridx_s; o.col = col_s;
        end
        return o;
    endfunction

`ifdef AES_SEQ_CYCLE_CNT_EN
    function automatic logic [15:0] get_cnt(input int sel);
        return (sel == 0) ? cnt_d : cnt_s;
    endfunction
`endif

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_d = v;
        else          start_s = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after each edge, starting with the edge that samples start high.
    task automatic build_model(input int nr, input int kc);
        exp_q.delete();
        exp_q.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        repeat (kc) exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 1, 2, nr, 0));
        for (int rnd = nr - 1; rnd >= 0; rnd--) begin
            exp_q.push_back(mk(0, 1, 0, 1, 3, 0, 0));
            exp_q.push_back(mk(0, 1, 0, 1, 4, 0, 0));
            exp_q.push_back(mk(0, 1, 0, 1, 2, rnd, 0));
            if (rnd != 0)
                for (int c = 0; c < 4; c++) exp_q.push_back(mk(0, 1, 0, 1, 5, 0, c));
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    endtask

    // Raises start and follows one run; abort_at >= 0 drops start after that step.
    task automatic run_seq(input int sel, input int nr, input int kc, input int abort_at);
        int   lat;
        int   first_done;
        int   ld_cnt;
        int   kx_cnt;
        int   exp_ld;
        int   ark_q[$];
        bit   ok;
        obs_t o;
        lat        = 7 * nr + kc - 2;
        first_done = -1;
        ld_cnt     = 0;
        kx_cnt     = 0;
        exp_ld     = 0;
        build_model(nr, kc);
        foreach (exp_q[i]) if (exp_q[i].ld) exp_ld++;
        set_start(sel, 1'b1);
        for (int j = 0; j < exp_q.size(); j++) begin
            tick();
            o = get_obs(sel);
            checks++;
            if (o !== exp_q[j]) begin
                errors++;
                $display("FAIL seq_step sel=%0d step=%0d got=%h expected=%h", sel, j, o, exp_q[j]);
            end
            if (o.done === 1'b1 && first_done < 0) first_done = j;
            if (o.ld === 1'b1) ld_cnt++;
            if (o.kexp === 1'b1) kx_cnt++;
            if (o.ld === 1'b1 && o.op == 3'd2) ark_q.push_back(int'(o.ridx));
            if (j == abort_at) begin
                set_start(sel, 1'b0);
                tick();
                o = get_obs(sel);
                checks++;
                if (o !== '0) begin
                    errors++;
                    $display("FAIL abort_idle sel=%0d step=%0d got=%h expected=0", sel, j, o);
                end
                checks++;
                if (first_done != -1) begin
                    errors++;
                    $display("FAIL abort_no_done sel=%0d done_seen_at=%0d expected=none", sel, first_done);
                end
`ifdef AES_SEQ_CYCLE_CNT_EN
                checks++;
                if (get_cnt(sel) !== 16'(abort_at + 1)) begin
                    errors++;
                    $display("FAIL abort_cycle_cnt sel=%0d got=%0d expected=%0d", sel, get_cnt(sel), abort_at + 1);
                end
`endif
                return;
            end
        end
        checks++;
        if (first_done != lat) begin
            errors++;
            $display("FAIL latency sel=%0d got=%0d expected=%0d", sel, first_done, lat);
        end
        checks++;
        if (ld_cnt != exp_ld) begin
            errors++;
            $display("FAIL state_ld_pulses sel=%0d got=%0d expected=%0d", sel, ld_cnt, exp_ld);
        end
        checks++;
        if (kx_cnt != kc) begin
            errors++;
            $display("FAIL keyexp_cycles sel=%0d got=%0d expected=%0d", sel, kx_cnt, kc);
        end
        ok = (ark_q.size() == nr + 1);
        if (ok) foreach (ark_q[i]) if (ark_q[i] != nr - i) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ark_round_seq sel=%0d got_len=%0d expected_len=%0d first=%0d", sel,
                     ark_q.size(), nr + 1, (ark_q.size() > 0) ? ark_q[0] : -1);
        end
`ifdef AES_SEQ_CYCLE_CNT_EN
        checks++;
        if (get_cnt(sel) !== 16'(lat)) begin
            errors++;
            $display("FAIL cycle_cnt sel=%0d got=%0d expected=%0d", sel, get_cnt(sel), lat);
        end
`endif
    endtask

    task automatic hold_release(input int sel, input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            tick();
            o = get_obs(sel);
            checks++;
            if (o !== mk(1, 0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL hold_done sel=%0d cycle=%0d got=%h expected=%h", sel, i, o, mk(1, 0, 0, 0, 0, 0, 0));
            end
        end
        set_start(sel, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            o = get_obs(sel);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL release_idle sel=%0d cycle=%0d got=%h expected=0", sel, i, o);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (get_obs(s) !== '0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d got=%h expected=0", s, get_obs(s));
            end
`ifdef AES_SEQ_CYCLE_CNT_EN
            checks++;
            if (get_cnt(s) !== 16'd0) begin
                errors++;
                $display("FAIL reset_cycle_cnt sel=%0d got=%0d expected=0", s, get_cnt(s));
            end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (get_obs(0) !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h expected=0", get_obs(0));
        end
    endtask

    task automatic test_full_run();
        run_seq(0, 10, 2, -1);
        hold_release(0, 10);
    endtask

    task automatic test_abort();
        run_seq(0, 10, 2, 20);
        tick();
        run_seq(0, 10, 2, -1);
        hold_release(0, 1);
        run_seq(0, 10, 2, int'($urandom_range(0, 69)));
        run_seq(0, 10, 2, 69);
        run_seq(0, 10, 2, -1);
        hold_release(0, int'($urandom_range(1, 6)));
    endtask

    task automatic test_reset_mid();
        int   j_imc;
        obs_t o;
        build_model(10, 2);
        j_imc = -1;
        foreach (exp_q[i]) if (j_imc < 0 && exp_q[i].op == 3'd5) j_imc = i;
        j_imc = j_imc + 1 + int'($urandom_range(0, 2));
        set_start(0, 1'b1);
        for (int j = 0; j <= j_imc; j++) tick();
        checks++;
        if (get_obs(0).op !== 3'd5) begin
            errors++;
            $display("FAIL reached_imc got_op=%0d expected=5", get_obs(0).op);
        end
        #2 rst_n = 1'b0;
        #1;
        o = get_obs(0);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got=%h expected=0", o);
        end
        set_start(0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (get_obs(0) !== '0) begin
            errors++;
            $display("FAIL idle_after_release got=%h expected=0", get_obs(0));
        end
`ifdef AES_SEQ_CYCLE_CNT_EN
        checks++;
        if (get_cnt(0) !== 16'd0) begin
            errors++;
            $display("FAIL cycle_cnt_after_reset got=%0d expected=0", get_cnt(0));
        end
`endif
        run_seq(0, 10, 2, -1);
        hold_release(0, 2);
    endtask

    task automatic test_small();
        run_seq(1, 2, 1, -1);
        hold_release(1, int'($urandom_range(1, 5)));
        run_seq(1, 2, 1, int'($urandom_range(0, 11)));
        run_seq(1, 2, 1, 11);
        run_seq(1, 2, 1, -1);
        hold_release(1, 1);
    endtask

    task automatic test_back_to_back();
        int sel;
        for (int it = 0; it < 4; it++) begin
            sel = int'($urandom_range(0, 1));
            repeat (int'($urandom_range(0, 3))) tick();
            if (sel == 0) run_seq(0, 10, 2, -1);
            else          run_seq(1, 2, 1, -1);
            hold_release(sel, int'($urandom_range(1, 8)));
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_reset_mid();
        test_small();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
